// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the processor: 256 x 8 storage with a registered
// read port, a req/ack loader port for preload/dump, and saturating access counters.
module data_mem_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // processor port (no handshake, one access per cycle)
  input  logic             data_mem_rd_enb_i,
  input  logic             data_mem_wr_enb_i,
  input  logic [7:0]       data_mem_addr_i,
  input  logic [7:0]       data_mem_wr_data_i,
  output logic [7:0]       data_mem_rd_data_o,
  // loader port
  input  logic             ld_req_i,
  input  logic             ld_we_i,
  input  logic [7:0]       ld_addr_i,
  input  logic [7:0]       ld_wdata_i,
  output logic             ld_ack_o,
  output logic [7:0]       ld_rdata_o,
  // access counters
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  // loader FSM state, for debug and checkers
  output logic [1:0]       ld_state_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  logic [7:0] mem [256];
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       proc_active;
  logic       ld_access;

  // Loader handshake: requester raises ld_req_i (level) with we/addr/wdata
  // stable; the block answers with a one-cycle ld_ack_o, after which the
  // request may drop. Requests are not re-accepted until the cycle after ack.
  assign proc_active = data_mem_rd_enb_i | data_mem_wr_enb_i;
  assign ld_access   = (state == ST_ACCESS) && !proc_active;
  assign ld_ack_o    = (state == ST_ACK);
  assign ld_state_o  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (ld_req_i && !ld_ack_o) state_nxt = ST_ACCESS;
      ST_ACCESS: if (!proc_active) state_nxt = ST_ACK;
      ST_ACK:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Storage is never cleared; reset only suppresses writes from both ports.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (data_mem_wr_enb_i)
        mem[data_mem_addr_i] <= data_mem_wr_data_i;
      else if (ld_access && ld_we_i)
        mem[ld_addr_i] <= ld_wdata_i;
    end
  end

  // Non-blocking read of mem gives read-before-write on a same-cycle rd+wr.
  always_ff @(posedge clk) begin
    if (rst)                    data_mem_rd_data_o <= 8'h00;
    else if (data_mem_rd_enb_i) data_mem_rd_data_o <= mem[data_mem_addr_i];
  end

  always_ff @(posedge clk) begin
    if (rst)                        ld_rdata_o <= 8'h00;
    else if (ld_access && !ld_we_i) ld_rdata_o <= mem[ld_addr_i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else begin
      if (data_mem_rd_enb_i && (rd_cnt_o != '1)) rd_cnt_o <= rd_cnt_o + CNT_W'(1);
      if (data_mem_wr_enb_i && (wr_cnt_o != '1)) wr_cnt_o <= wr_cnt_o + CNT_W'(1);
    end
  end

endmodule
